// File: rtl/req_grant_scheduler_pkg.sv
// Shared types and helpers for the request/grant scheduler.
// Holds the FSM encoding, default widths and the one-hot encoder.
package req_grant_scheduler_pkg;

  localparam int DEF_N    = 8;
  localparam int DEF_IDXW = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_e;

  // A zero vector encodes to 0, which is also the idle value of the index.
  function automatic logic [DEF_IDXW-1:0] onehot_to_idx(input logic [DEF_N-1:0] oh);
    logic [DEF_IDXW-1:0] idx;
    idx = '0;
    for (int i = 0; i < DEF_N; i++) begin
      if (oh[i]) idx = idx | DEF_IDXW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/req_grant_scheduler_arb.sv
// Rightmost-one priority arbiter: the lowest set request bit wins.
// Purely combinational; an all-zero request gives an all-zero grant.
module req_grant_scheduler_arb #(
  parameter int W = 8
) (
  input  logic [W-1:0] req,
  output logic [W-1:0] gnt
);

  assign gnt = req & (~req + W'(1));

endmodule

// File: rtl/req_grant_scheduler.sv
// Captures request pulses into a sticky pending set and offers them one at a
// time, lowest index first, under a valid/ready handshake.
//
//   state    | meaning
//   ST_IDLE  | no grant offered; loads the next request as soon as one is pending
//   ST_OFFER | grant held stable until gnt_ready; then reloads or returns to idle
module req_grant_scheduler
  import req_grant_scheduler_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int IDXW = DEF_IDXW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_in,
  input  logic            clr,
  input  logic            gnt_ready,
  output logic            gnt_valid,
  output logic [N-1:0]    gnt_onehot,
  output logic [IDXW-1:0] gnt_idx,
  output logic [N-1:0]    pending,
  output logic [7:0]      gnt_count
);

  state_e          state_q, state_d;
  logic [N-1:0]    pending_q, pending_d;
  logic [N-1:0]    gnt_onehot_q, gnt_onehot_d;
  logic [IDXW-1:0] gnt_idx_q, gnt_idx_d;
  logic            gnt_valid_q, gnt_valid_d;
  logic [7:0]      gnt_count_q, gnt_count_d;

  logic [N-1:0]    sel;
  logic            hs;
  logic            load;

  req_grant_scheduler_arb #(.W(N)) u_arb (
    .req (pending_q),
    .gnt (sel)
  );

  assign hs   = (state_q == ST_OFFER) && gnt_ready;
  assign load = (|pending_q) && ((state_q == ST_IDLE) || hs);

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    gnt_onehot_d = gnt_onehot_q;
    gnt_idx_d    = gnt_idx_q;
    gnt_valid_d  = gnt_valid_q;
    // A handshake completing in the clr cycle still counts.
    gnt_count_d  = hs ? gnt_count_q + 8'd1 : gnt_count_q;

    if (clr) begin
      state_d      = ST_IDLE;
      pending_d    = '0;
      gnt_onehot_d = '0;
      gnt_idx_d    = '0;
      gnt_valid_d  = 1'b0;
    end else begin
      // req_in is ORed after removal so a same-cycle re-request stays pending.
      pending_d = (pending_q & ~(load ? sel : '0)) | req_in;
      if (load) begin
        state_d      = ST_OFFER;
        gnt_onehot_d = sel;
        gnt_idx_d    = onehot_to_idx(sel);
        gnt_valid_d  = 1'b1;
      end else if (hs) begin
        state_d      = ST_IDLE;
        gnt_onehot_d = '0;
        gnt_idx_d    = '0;
        gnt_valid_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pending_q    <= '0;
      gnt_onehot_q <= '0;
      gnt_idx_q    <= '0;
      gnt_valid_q  <= 1'b0;
      gnt_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      gnt_onehot_q <= gnt_onehot_d;
      gnt_idx_q    <= gnt_idx_d;
      gnt_valid_q  <= gnt_valid_d;
      gnt_count_q  <= gnt_count_d;
    end
  end

  assign gnt_valid  = gnt_valid_q;
  assign gnt_onehot = gnt_onehot_q;
  assign gnt_idx    = gnt_idx_q;
  assign pending    = pending_q;
  assign gnt_count  = gnt_count_q;

endmodule

// File: tb/tb_req_grant_scheduler.sv
// Directed bench for req_grant_scheduler with hand-computed expectations.
module tb_req_grant_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_in;
  logic       clr;
  logic       gnt_ready;
  logic       gnt_valid;
  logic [7:0] gnt_onehot;
  logic [2:0] gnt_idx;
  logic [7:0] pending;
  logic [7:0] gnt_count;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  req_grant_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_in     (req_in),
    .clr        (clr),
    .gnt_ready  (gnt_ready),
    .gnt_valid  (gnt_valid),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .pending    (pending),
    .gnt_count  (gnt_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] oh,
                         input logic [2:0] idx, input logic [7:0] pend, input logic [7:0] cnt);
    chk({tag, "_valid"},   {31'd0, gnt_valid}, {31'd0, v});
    chk({tag, "_onehot"},  {24'd0, gnt_onehot}, {24'd0, oh});
    chk({tag, "_idx"},     {29'd0, gnt_idx}, {29'd0, idx});
    chk({tag, "_pending"}, {24'd0, pending}, {24'd0, pend});
    chk({tag, "_count"},   {24'd0, gnt_count}, {24'd0, cnt});
  endtask

  initial begin
    bit reached;
    rst_n = 1'b0; req_in = '0; clr = 1'b0; gnt_ready = 1'b0;
    #1;
    chk_out("reset", 1'b0, 8'h00, 3'd0, 8'h00, 8'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk_out("idle_no_req", 1'b0, 8'h00, 3'd0, 8'h00, 8'd0);

    // Three requests served lowest first, one per cycle.
    req_in = 8'b0010_1010; gnt_ready = 1'b1;
    tick(); req_in = '0;
    chk_out("t2_capture", 1'b0, 8'h00, 3'd0, 8'h2A, 8'd0);
    tick(); chk_out("t2_g1", 1'b1, 8'h02, 3'd1, 8'h28, 8'd0);
    tick(); chk_out("t2_g2", 1'b1, 8'h08, 3'd3, 8'h20, 8'd1);
    tick(); chk_out("t2_g3", 1'b1, 8'h20, 3'd5, 8'h00, 8'd2);
    tick(); chk_out("t2_done", 1'b0, 8'h00, 3'd0, 8'h00, 8'd3);

    // Stalled offer is not re-arbitrated when a lower index arrives.
    gnt_ready = 1'b0; req_in = 8'h02;
    tick(); req_in = '0;
    tick(); chk_out("t3_offer", 1'b1, 8'h02, 3'd1, 8'h00, 8'd3);
    tick(); tick(); tick();
    chk_out("t3_hold", 1'b1, 8'h02, 3'd1, 8'h00, 8'd3);
    req_in = 8'h01;
    tick(); req_in = '0;
    chk_out("t3_lowreq", 1'b1, 8'h02, 3'd1, 8'h01, 8'd3);
    gnt_ready = 1'b1;
    tick(); chk_out("t3_next", 1'b1, 8'h01, 3'd0, 8'h00, 8'd4);
    tick(); chk_out("t3_done", 1'b0, 8'h00, 3'd0, 8'h00, 8'd5);

    // Stream bit 0 until the count reaches 250, then drain to exactly 252.
    req_in = 8'h01; reached = 1'b0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (gnt_count == 8'd250) begin
        reached = 1'b1;
        break;
      end
    end
    chk("t4_reach250", {31'd0, reached}, 32'd1);
    req_in = '0;
    tick(); tick();
    chk_out("t4_pre", 1'b0, 8'h00, 3'd0, 8'h00, 8'd252);

    // Full burst: idx 0..7 back-to-back with count wrapping through 255.
    req_in = 8'hFF;
    tick(); req_in = '0;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] oh;
      logic [7:0] cnt;
      logic [7:0] pend;
      oh   = 8'h01 << i;
      cnt  = 8'(252 + i);
      pend = 8'hFF << (i + 1);
      tick();
      chk_out("t4_burst", 1'b1, oh, 3'(i), pend, cnt);
    end
    tick(); chk_out("t4_wrap", 1'b0, 8'h00, 3'd0, 8'h00, 8'd4);

    // Same-cycle re-request of the bit being loaded keeps it pending.
    req_in = 8'h05;
    tick(); req_in = '0;
    tick(); chk_out("t6_idx0", 1'b1, 8'h01, 3'd0, 8'h04, 8'd4);
    req_in = 8'h04;
    tick(); req_in = '0;
    chk_out("t6_idx2", 1'b1, 8'h04, 3'd2, 8'h04, 8'd5);
    tick(); chk_out("t6_again", 1'b1, 8'h04, 3'd2, 8'h00, 8'd6);
    tick(); chk_out("t6_done", 1'b0, 8'h00, 3'd0, 8'h00, 8'd7);

    // clr mid-burst: completing handshake counts, same-cycle req is dropped.
    req_in = 8'hFF;
    tick(); req_in = '0;
    tick(); tick(); tick();
    chk_out("t5_pre", 1'b1, 8'h04, 3'd2, 8'hF8, 8'd9);
    clr = 1'b1; req_in = 8'h01;
    tick(); clr = 1'b0; req_in = '0;
    chk_out("t5_clr", 1'b0, 8'h00, 3'd0, 8'h00, 8'd10);
    tick(); tick(); tick();
    chk_out("t5_quiet", 1'b0, 8'h00, 3'd0, 8'h00, 8'd10);

    // An offer removed by clr without a handshake does not count.
    gnt_ready = 1'b0; req_in = 8'h02;
    tick(); req_in = '0;
    tick(); chk_out("clr_offer_pre", 1'b1, 8'h02, 3'd1, 8'h00, 8'd10);
    clr = 1'b1;
    tick(); clr = 1'b0;
    chk_out("clr_offer", 1'b0, 8'h00, 3'd0, 8'h00, 8'd10);

    // Asynchronous reset mid-offer with F0 still pending.
    req_in = 8'hF1;
    tick(); req_in = '0;
    tick(); chk_out("t1_pre", 1'b1, 8'h01, 3'd0, 8'hF0, 8'd10);
    #2 rst_n = 1'b0;
    #1 chk_out("t1_async", 1'b0, 8'h00, 3'd0, 8'h00, 8'd0);
    tick(); rst_n = 1'b1; gnt_ready = 1'b1;
    tick(); tick(); tick();
    chk_out("t1_after", 1'b0, 8'h00, 3'd0, 8'h00, 8'd0);
    req_in = 8'h80;
    tick(); req_in = '0;
    tick(); chk_out("t1_newreq", 1'b1, 8'h80, 3'd7, 8'h00, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
